matvec_param: RTL and testbench



---
 rtl/matvec_param.sv | 168 ++++++++++++++++
 tb/tb_matvec_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_param.sv
// matvec_param: KxK signed matrix-vector multiplier with matrix reuse.
// W (row-major) is loaded only when new_matrix is set on the first word of a
// product, then x is loaded, then y = W*x is streamed out one row per handshake.
// A single MAC runs as a 2-stage pipe (registered multiply, registered accumulate).
// Optional feature: define MATVEC_RELU_EN to clamp negative results to zero.
module matvec_param #(
  parameter int K  = 3,
  parameter int T  = 14,
  parameter int OW = 2*T
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [T-1:0]  input_data,
  input  logic          new_matrix,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [OW-1:0] output_data
);
  localparam int AW     = 2*T + $clog2(K);
  localparam int WW     = $clog2(K*K);
  localparam int XW     = $clog2(K);
  localparam int CW     = $clog2(K+1);
  localparam int STAGES = 1;  // stage 0: product register, stage 1: accumulator

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [WW-1:0] W_LAST = WW'(K*K-1);
  localparam logic [XW-1:0] X_LAST = XW'(K-1);
  localparam logic [CW-1:0] C_LAST = CW'(K-1);
  localparam logic [CW-1:0] C_DONE = CW'(K);

  logic [2:0]             state;
  logic [K*K-1:0][T-1:0]  w_mem;
  logic [K-1:0][T-1:0]    x_mem;
  logic [WW-1:0]          w_addr;
  logic [XW-1:0]          x_addr;
  logic [XW-1:0]          row;
  logic [CW-1:0]          col;

  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0]        last_pipe;
  logic                   first_p;
  logic signed [2*T-1:0]  prod;
  logic signed [AW-1:0]   acc;

  logic                   in_fire;
  logic                   issue;
  logic [WW-1:0]          w_idx;
  logic signed [T-1:0]    w_op;
  logic signed [T-1:0]    x_op;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_base;
  logic [OW-1:0]          y_next;
  logic                   acc_unused;

  // Handshake, MAC operand selection and result formatting
  always_comb begin
    input_ready = !reset && (state == S_IDLE || state == S_LOAD_W || state == S_LOAD_X);
    in_fire     = input_valid && input_ready;
    issue       = (state == S_COMPUTE) && (col != C_DONE);
    w_idx       = WW'(row * K) + WW'(col);
    w_op        = w_mem[w_idx];
    x_op        = x_mem[XW'(col)];
    prod_ext    = {{(AW-2*T){prod[2*T-1]}}, prod};
    acc_base    = first_p ? '0 : acc;
`ifdef MATVEC_RELU_EN
    // sign comes from the full-width accumulator, not the truncated result
    y_next      = acc[AW-1] ? '0 : acc[OW-1:0];
`else
    y_next      = acc[OW-1:0];
`endif
  end

  // Upper accumulator bits only matter for the clamp; output wraps to OW
  assign acc_unused = ^acc[AW-1:OW];

  // MAC pipe: one product per issue cycle, accumulator restarts on column 0
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      first_p   <= 1'b0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
      last_pipe <= {last_pipe[STAGES-1:0], issue && (col == C_LAST)};
      if (issue) begin
        prod    <= w_op * x_op;
        first_p <= (col == '0);
      end
      if (vld_pipe[0]) acc <= acc_base + prod_ext;
    end
  end

  // Control FSM: load W/x, sequence rows through the MAC, hold each result
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      w_mem        <= '0;
      x_mem        <= '0;
      w_addr       <= '0;
      x_addr       <= '0;
      row          <= '0;
      col          <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_fire) begin
          if (new_matrix) begin
            w_mem[0] <= input_data;
            w_addr   <= WW'(1);
            state    <= S_LOAD_W;
          end else begin
            x_mem[0] <= input_data;
            x_addr   <= XW'(1);
            state    <= S_LOAD_X;
          end
        end
        S_LOAD_W: if (in_fire) begin
          w_mem[w_addr] <= input_data;
          if (w_addr == W_LAST) begin
            x_addr <= '0;
            state  <= S_LOAD_X;
          end else begin
            w_addr <= w_addr + WW'(1);
          end
        end
        S_LOAD_X: if (in_fire) begin
          x_mem[x_addr] <= input_data;
          if (x_addr == X_LAST) begin
            row   <= '0;
            col   <= '0;
            state <= S_COMPUTE;
          end else begin
            x_addr <= x_addr + XW'(1);
          end
        end
        S_COMPUTE: begin
          if (issue) col <= col + CW'(1);
          if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
            output_data  <= y_next;
            output_valid <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: if (output_ready) begin
          output_valid <= 1'b0;
          if (row == X_LAST) begin
            state <= S_IDLE;
          end else begin
            row   <= row + XW'(1);
            col   <= '0;
            state <= S_COMPUTE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matvec_param.sv
// Self-checking bench for matvec_param (K=3, T=14, OW=28). Reference model keeps
// W and x as integer arrays and computes each y row as a plain dot product.
module tb_matvec_param;
  localparam int K  = 3;
  localparam int T  = 14;
  localparam int OW = 2*T;

  logic          clk = 1'b0;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic [T-1:0]  input_data;
  logic          new_matrix;
  logic          output_valid;
  logic          output_ready;
  logic [OW-1:0] output_data;

  int total = 0;
  int bad   = 0;
  int wm[K*K];
  int xm[K];

  always #5 clk = ~clk;

  matvec_param #(.K(K), .T(T), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .new_matrix(new_matrix),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] ref_y(input int r);
    longint s = 0;
    for (int c = 0; c < K; c++) s += longint'(wm[r*K+c]) * longint'(xm[c]);
`ifdef MATVEC_RELU_EN
    if (s < 0) return '0;
`endif
    return OW'(s);
  endfunction

  function automatic int rnd_word();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic send_word(input int d, input logic nm);
    int n;
    bit fire;
    repeat ($urandom_range(0, 2)) begin
      input_valid = 1'b0; input_data = 'x; new_matrix = 1'bx;
      @(negedge clk);
    end
    input_valid = 1'b1; input_data = T'(d); new_matrix = nm;
    n = 0; fire = 0;
    while (!fire && n < 200) begin
      fire = input_ready;
      @(negedge clk);
      n++;
    end
    input_valid = 1'b0; input_data = 'x; new_matrix = 1'bx;
    if (!fire) begin
      total++; bad++;
      $display("FAIL send_word timeout got=no_accept exp=accept");
    end
  endtask

  task automatic collect_rows(input int hold);
    int n;
    bit fire;
    logic [OW-1:0] exp, d0;
    for (int r = 0; r < K; r++) begin
      exp = ref_y(r);
      n = 0;
      while (!output_valid && n < 200) begin
        output_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      output_ready = 1'b0;
      total++;
      if (n !== K + 2) begin
        bad++;
        $display("FAIL latency row%0d got=%0d exp=%0d", r, n, K + 2);
      end
      d0 = output_data;
      total++;
      if (output_data !== exp) begin
        bad++;
        $display("FAIL y_row%0d got=%0d exp=%0d", r, $signed(output_data), $signed(exp));
      end
      if (r == 0 && hold > 0) begin
        repeat (hold) begin
          input_valid = 1'b1; input_data = T'(rnd_word()); new_matrix = 1'($urandom_range(0, 1));
          @(negedge clk);
          total++;
          if (output_valid !== 1'b1 || output_data !== d0 || input_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold got=v%0b d%0d ir%0b exp=v1 d%0d ir0",
                     output_valid, $signed(output_data), input_ready, $signed(d0));
          end
        end
        input_valid = 1'b0; input_data = 'x; new_matrix = 1'bx;
        output_ready = 1'b1;
        @(negedge clk);
        output_ready = 1'b0;
      end else begin
        fire = 0; n = 0;
        while (!fire && n < 200) begin
          output_ready = ($urandom_range(0, 3) != 0);
          fire = output_ready;
          @(negedge clk);
          n++;
          if (!fire) begin
            total++;
            if (output_valid !== 1'b1 || output_data !== d0) begin
              bad++;
              $display("FAIL stall_stable got=v%0b d%0d exp=v1 d%0d",
                       output_valid, $signed(output_data), $signed(d0));
            end
          end
        end
        output_ready = 1'b0;
      end
    end
    total++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      bad++;
      $display("FAIL end_of_product got=v%0b ir%0b exp=v0 ir1", output_valid, input_ready);
    end
  endtask

  task automatic run_product(input bit nm, input int w_in[K*K], input int x_in[K], input int hold);
    if (nm) begin
      for (int i = 0; i < K*K; i++) begin
        send_word(w_in[i], (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        wm[i] = w_in[i];
      end
    end
    for (int c = 0; c < K; c++) begin
      send_word(x_in[c], (c == 0 && !nm) ? 1'b0 : 1'($urandom_range(0, 1)));
      xm[c] = x_in[c];
    end
    total++;
    if (input_ready !== 1'b0) begin
      bad++;
      $display("FAIL words_accepted got=ir%0b exp=ir0", input_ready);
    end
    collect_rows(hold);
  endtask

  task automatic test_reset();
    reset = 1'b1; input_valid = 1'b0; input_data = '0; new_matrix = 1'b0; output_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (output_valid !== 1'b0 || output_data !== '0 || input_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=v%0b d%0d ir%0b exp=v0 d0 ir0",
               output_valid, output_data, input_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (input_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got=ir%0b exp=ir1", input_ready);
    end
    foreach (wm[i]) wm[i] = 0;
  endtask

  task automatic test_identity();
    int w[K*K] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int x[K]   = '{5, -7, 9};
    run_product(1'b1, w, x, 0);
  endtask

  task automatic test_reuse();
    int w[K*K] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int x0[K]  = '{-100, 200, 37};
    int x[K]   = '{1, 2, 3};
    run_product(1'b1, w, x0, 0);
    run_product(1'b0, w, x, 0);
  endtask

  task automatic test_wrap();
    int w[K*K];
    int x[K];
    foreach (w[i]) w[i] = -8192;
    foreach (x[i]) x[i] = -8192;
    run_product(1'b1, w, x, 0);
  endtask

  task automatic test_backpressure();
    int w[K*K];
    int x[K];
    foreach (w[i]) w[i] = rnd_word();
    foreach (x[i]) x[i] = rnd_word();
    run_product(1'b1, w, x, 20);
  endtask

  task automatic test_reset_mid();
    int w[K*K];
    int x[K] = '{3, 3, 3};
    for (int i = 0; i < 4; i++) send_word(rnd_word() | 1, (i == 0) ? 1'b1 : 1'b0);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (output_valid !== 1'b0 || input_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=v%0b ir%0b exp=v0 ir0", output_valid, input_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (input_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_idle got=ir%0b exp=ir1", input_ready);
    end
    foreach (wm[i]) wm[i] = 0;
    foreach (w[i]) w[i] = 0;
    run_product(1'b0, w, x, 0);
  endtask

  task automatic test_back_to_back();
    int w[K*K];
    int x[K];
    for (int p = 0; p < 400; p++) begin
      foreach (w[i]) w[i] = ($urandom_range(0, 15) == 0) ? -8192 : rnd_word();
      foreach (x[i]) x[i] = ($urandom_range(0, 15) == 0) ? 8191 : rnd_word();
      run_product(1'($urandom_range(0, 1)), w, x, 0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reuse();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
